// File: rtl/uop_dispatch.sv
// rtl/uop_dispatch.sv - micro-op command responder: validate, launch one engine, report completion
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   cmd_op/slot_a/slot_b/param      command fields, sampled with cmd_start in S_IDLE
//   cmd_start                       one-cycle command strobe (ignored while busy)
//   cmd_done, cmd_err, cmd_err_code one-cycle completion pulse with status
//                                   (0 ok, 1 illegal op, 2 bad slot/param, 3 timeout)
//   busy                            high whenever the FSM is not in S_IDLE
//   eng_start / eng_done            one-hot engine start pulse / per-engine completion
//   eng_op/slot_a/slot_b/param      latched command fields routed to the engines
//
// Build option: define UOP_DISPATCH_TIMEOUT_EN to add a TIMEOUT_CYCLES watchdog in S_WAIT.
module uop_dispatch #(
    parameter int unsigned NUM_SLOTS = 20
`ifdef UOP_DISPATCH_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd8192
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cmd_op,
    input  logic [4:0] cmd_slot_a,
    input  logic [4:0] cmd_slot_b,
    input  logic [3:0] cmd_param,
    input  logic       cmd_start,
    output logic       cmd_done,
    output logic       cmd_err,
    output logic [1:0] cmd_err_code,
    output logic       busy,
    output logic [5:0] eng_start,
    input  logic [5:0] eng_done,
    output logic [3:0] eng_op,
    output logic [4:0] eng_slot_a,
    output logic [4:0] eng_slot_b,
    output logic [3:0] eng_param
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WAIT} state_t;

    state_t     state, state_nx;
    logic [5:0] op_sel;
    logic       needs_a, needs_b;
    logic       illegal_op, slot_bad, param_bad;
    logic [1:0] chk_code;
    logic       done_nx, err_nx;
    logic [1:0] code_nx;
    logic [5:0] start_nx;
    logic       latch;

    // Decode the latched op: target engine and which slot fields it uses.
    // eng_op cannot change while busy, so op_sel also identifies the engine in flight.
    always_comb begin
        op_sel  = 6'b000000;
        needs_a = 1'b0;
        needs_b = 1'b0;
        case (eng_op)
            4'd1, 4'd2, 4'd4, 4'd5, 4'd6: begin op_sel = 6'b000001; needs_a = 1'b1; end
            4'd3:                         begin op_sel = 6'b000010; end
            4'd7:                         begin op_sel = 6'b000100; end
            4'd8, 4'd9:                   begin op_sel = 6'b001000; needs_a = 1'b1; needs_b = 1'b1; end
            4'd10, 4'd11:                 begin op_sel = 6'b010000; needs_a = 1'b1; needs_b = 1'b1; end
            4'd12:                        begin op_sel = 6'b100000; needs_a = 1'b1; end
            default:                      begin op_sel = 6'b000000; end
        endcase
        illegal_op = (eng_op >= 4'd13);
        slot_bad   = (needs_a && ({27'd0, eng_slot_a} >= NUM_SLOTS)) ||
                     (needs_b && ({27'd0, eng_slot_b} >= NUM_SLOTS));
        param_bad  = ((eng_op == 4'd3) && (eng_param > 4'd1)) ||
                     (((eng_op == 4'd10) || (eng_op == 4'd11)) &&
                      !((eng_param == 4'd1) || (eng_param == 4'd4) ||
                        (eng_param == 4'd10) || (eng_param == 4'd11)));
        if (illegal_op)
            chk_code = 2'd1;
        else if (slot_bad || param_bad)
            chk_code = 2'd2;
        else
            chk_code = 2'd0;
    end

`ifdef UOP_DISPATCH_TIMEOUT_EN
    logic [15:0] wd_count;

    // Cleared while in S_CHECK so it reads zero on the first S_WAIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_count <= 16'd0;
        else if (state == S_CHECK)
            wd_count <= 16'd0;
        else if (state == S_WAIT)
            wd_count <= wd_count + 16'd1;
    end
`endif

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        code_nx  = 2'd0;
        start_nx = 6'b000000;
        latch    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start) begin
                    latch    = 1'b1;
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_code != 2'd0) begin
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    code_nx  = chk_code;
                    state_nx = S_IDLE;
                end else if (eng_op == 4'd0) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    start_nx = op_sel;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                // A done that coincides with our own start pulse cannot belong to this launch.
                if ((eng_start == 6'b000000) && ((eng_done & op_sel) != 6'b000000)) begin
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
`ifdef UOP_DISPATCH_TIMEOUT_EN
                else if (wd_count == TIMEOUT_CYCLES) begin
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                    code_nx  = 2'd3;
                    state_nx = S_IDLE;
                end
`endif
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cmd_done     <= 1'b0;
            cmd_err      <= 1'b0;
            cmd_err_code <= 2'd0;
            eng_start    <= 6'b000000;
            eng_op       <= 4'd0;
            eng_slot_a   <= 5'd0;
            eng_slot_b   <= 5'd0;
            eng_param    <= 4'd0;
        end else begin
            state        <= state_nx;
            cmd_done     <= done_nx;
            cmd_err      <= err_nx;
            cmd_err_code <= code_nx;
            eng_start    <= start_nx;
            if (latch) begin
                eng_op     <= cmd_op;
                eng_slot_a <= cmd_slot_a;
                eng_slot_b <= cmd_slot_b;
                eng_param  <= cmd_param;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule
